// File: rtl/aes_cbc_sequencer.sv
// aes_cbc_sequencer: runs one iterative AES-128 core through a CBC
// encryption job of len_i blocks. Plaintext comes in on a valid/ready
// stream, is XORed with the chaining value and loaded into the core. The
// core result is sent out as ciphertext and becomes the next chaining value.
// Optional build macro AES_CBC_SEQ_WATCHDOG_EN adds a RUN-state watchdog
// that sets a sticky error. Without it, err_o is tied low.
`timescale 1ns/1ps
module aes_cbc_sequencer #(
  parameter int CNT_LEN = 1024,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       start_i,
  input  logic [$clog2(CNT_LEN):0]   len_i,
  input  logic [127:0]               iv_i,
  input  logic [127:0]               key_i,
  input  logic                       pt_valid_i,
  output logic                       pt_ready_o,
  input  logic [127:0]               pt_data_i,
  output logic                       core_ld_o,
  output logic [127:0]               core_key_o,
  output logic [127:0]               core_text_o,
  input  logic                       core_done_i,
  input  logic [127:0]               core_text_i,
  output logic                       ct_valid_o,
  input  logic                       ct_ready_i,
  output logic [127:0]               ct_data_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [$clog2(CNT_LEN):0]   cnt_o,
  output logic                       err_o
);

  localparam int CW = $clog2(CNT_LEN) + 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_IN = 3'd1,
    S_LOAD    = 3'd2,
    S_RUN     = 3'd3,
    S_OUT     = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [127:0]  chain_q, key_q, text_q, ct_q;
  logic [CW-1:0] cnt_q, len_q;
  logic          done_q;
  logic          last_s;
  logic          wd_expire_s;

  // The block now in OUT is the final block of the job.
  assign last_s = ((cnt_q + CNT_ONE) == len_q);

`ifdef AES_CBC_SEQ_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  logic [WW-1:0] wd_q;
  logic          err_q;

  assign wd_expire_s = (state_q == S_RUN) && (wd_q == WD_LAST);
  assign err_o       = err_q;

  // Watchdog: count RUN cycles. The count is cleared in LOAD so every block starts fresh.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q <= {WW{1'b0}};
    end else if (clear_i || (state_q == S_LOAD)) begin
      wd_q <= {WW{1'b0}};
    end else if (state_q == S_RUN) begin
      wd_q <= wd_q + {{(WW-1){1'b0}}, 1'b1};
    end
  end

  // Sticky error: set on watchdog expiry, cleared by clear or an accepted start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (clear_i) begin
      err_q <= 1'b0;
    end else if ((state_q == S_IDLE) && start_i) begin
      err_q <= 1'b0;
    end else if (wd_expire_s && !core_done_i) begin
      err_q <= 1'b1;
    end
  end
`else
  assign wd_expire_s = 1'b0;
  assign err_o       = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic. A clear overrides every transition.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i && (len_i != CNT_ZERO)) state_d = S_WAIT_IN;
          else                                state_d = S_IDLE;
        end
        S_WAIT_IN: begin
          if (pt_valid_i) state_d = S_LOAD;
          else            state_d = S_WAIT_IN;
        end
        S_LOAD: state_d = S_RUN;
        S_RUN: begin
          if (core_done_i)      state_d = S_OUT;
          else if (wd_expire_s) state_d = S_IDLE;
          else                  state_d = S_RUN;
        end
        S_OUT: begin
          if (ct_ready_i) state_d = last_s ? S_IDLE : S_WAIT_IN;
          else            state_d = S_OUT;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath: chain, key, core text, ciphertext, block counter and the zero-length done flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= 128'h0;
      key_q   <= 128'h0;
      text_q  <= 128'h0;
      ct_q    <= 128'h0;
      cnt_q   <= CNT_ZERO;
      len_q   <= CNT_ZERO;
      done_q  <= 1'b0;
    end else if (clear_i) begin
      cnt_q  <= CNT_ZERO;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (len_i != CNT_ZERO) begin
              chain_q <= iv_i;
              key_q   <= key_i;
              cnt_q   <= CNT_ZERO;
              len_q   <= len_i;
            end else begin
              done_q  <= 1'b1;
            end
          end
        end
        S_WAIT_IN: begin
          if (pt_valid_i) text_q <= pt_data_i ^ chain_q;
        end
        S_RUN: begin
          if (core_done_i) begin
            ct_q    <= core_text_i;
            chain_q <= core_text_i;
          end
        end
        S_OUT: begin
          if (ct_ready_i) cnt_q <= cnt_q + CNT_ONE;
        end
        default: begin
          chain_q <= chain_q;
        end
      endcase
    end
  end

  // Outputs decoded from registered state. The end-of-job done is flagged during the final handshake.
  always_comb begin
    pt_ready_o  = (state_q == S_WAIT_IN);
    core_ld_o   = (state_q == S_LOAD);
    ct_valid_o  = (state_q == S_OUT);
    busy_o      = (state_q != S_IDLE);
    done_o      = done_q;
    if ((state_q == S_OUT) && ct_ready_i && last_s && !clear_i) begin
      done_o = 1'b1;
    end else begin
      done_o = done_q;
    end
    core_key_o  = key_q;
    core_text_o = text_q;
    ct_data_o   = ct_q;
    cnt_o       = cnt_q;
  end

endmodule

// File: tb/tb_aes_cbc_sequencer.sv
// Directed testbench for aes_cbc_sequencer. It uses a behavioural
// 10-cycle cipher core model. The model returns the known AES-128 result
// for the standard test vector and a simple keyed mix for any other input.
`timescale 1ns/1ps
module tb_aes_cbc_sequencer;
  localparam int CNT_LEN = 1024;
  localparam int TIMEOUT = 64;
  localparam int CW      = 11;
  localparam int LAT     = 10;

  localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV1  = 128'hf0e0d0c0b0a090807060504030201000;
  localparam logic [127:0] IV2  = 128'h0123456789abcdeffedcba9876543210;

  logic          clk_i, rst_ni, clear_i, start_i;
  logic [CW-1:0] len_i;
  logic [127:0]  iv_i, key_i, pt_data_i;
  logic          pt_valid_i, pt_ready_o;
  logic          core_ld_o, core_done_i;
  logic [127:0]  core_key_o, core_text_o, core_text_i;
  logic          ct_valid_o, ct_ready_i;
  logic [127:0]  ct_data_o;
  logic          busy_o, done_o, err_o;
  logic [CW-1:0] cnt_o;

  int n_vec = 0;
  int n_err = 0;

  aes_cbc_sequencer #(.CNT_LEN(CNT_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .len_i(len_i), .iv_i(iv_i), .key_i(key_i),
    .pt_valid_i(pt_valid_i), .pt_ready_o(pt_ready_o), .pt_data_i(pt_data_i),
    .core_ld_o(core_ld_o), .core_key_o(core_key_o), .core_text_o(core_text_o),
    .core_done_i(core_done_i), .core_text_i(core_text_i),
    .ct_valid_o(ct_valid_o), .ct_ready_i(ct_ready_i), .ct_data_o(ct_data_o),
    .busy_o(busy_o), .done_o(done_o), .cnt_o(cnt_o), .err_o(err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Cipher core stand-in.
  function automatic logic [127:0] core_fn(input logic [127:0] t, input logic [127:0] k);
    if (t == PT0 && k == KEY0) return CT0;
    return {t[126:0], t[127]} ^ k ^ 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
  endfunction

  // Core model: a load starts a LAT-cycle computation. core_hang suppresses done.
  bit           core_hang = 1'b0;
  int           core_cnt;
  logic [127:0] core_res;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      core_done_i <= 1'b0;
      core_text_i <= 128'h0;
      core_cnt    <= 0;
      core_res    <= 128'h0;
    end else begin
      core_done_i <= 1'b0;
      if (core_ld_o) begin
        core_cnt <= LAT - 1;
        core_res <= core_fn(core_text_o, core_key_o);
      end else if (core_cnt == 1) begin
        core_cnt <= 0;
        if (!core_hang) begin
          core_done_i <= 1'b1;
          core_text_i <= core_res;
        end
      end else if (core_cnt > 1) begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  // Event monitors: load pulses, text loaded into the core, done pulses.
  int           ld_cnt = 0;
  int           done_cnt = 0;
  logic [127:0] last_ld_text = 128'h0;
  always @(posedge clk_i) begin
    if (core_ld_o) begin
      ld_cnt       <= ld_cnt + 1;
      last_ld_text <= core_text_o;
    end
    if (done_o) done_cnt <= done_cnt + 1;
  end

  task automatic start_job(input logic [CW-1:0] len, input logic [127:0] iv, input logic [127:0] key);
    @(negedge clk_i);
    start_i = 1'b1; len_i = len; iv_i = iv; key_i = key;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic send_pt(input logic [127:0] pt);
    int t = 0;
    while (!pt_ready_o && t < 50) begin @(negedge clk_i); t++; end
    n_vec++;
    if (pt_ready_o !== 1'b1) begin n_err++; $display("FAIL pt_ready_wait: pt_ready_o=%b required 1", pt_ready_o); end
    pt_valid_i = 1'b1; pt_data_i = pt;
    @(negedge clk_i);
    pt_valid_i = 1'b0;
  endtask

  task automatic wait_ct_valid();
    int t = 0;
    while (!ct_valid_o && t < 100) begin @(negedge clk_i); t++; end
    n_vec++;
    if (ct_valid_o !== 1'b1) begin n_err++; $display("FAIL ct_valid_wait: ct_valid_o=%b required 1", ct_valid_o); end
  endtask

  task automatic recv_ct(output logic [127:0] ct);
    wait_ct_valid();
    ct = ct_data_o;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if ({pt_ready_o, core_ld_o, ct_valid_o, busy_o, done_o, err_o} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags: got %b required 000000", {pt_ready_o, core_ld_o, ct_valid_o, busy_o, done_o, err_o});
    end
    n_vec++;
    if (cnt_o !== 11'd0) begin n_err++; $display("FAIL reset_cnt: got %0d required 0", cnt_o); end
    n_vec++;
    if ({core_text_o, core_key_o, ct_data_o} !== 384'h0) begin n_err++; $display("FAIL reset_data: text/key/ct not all zero"); end
    @(negedge clk_i); rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_single_block();
    logic [127:0] ct;
    int d0 = done_cnt;
    start_job(11'd1, 128'h0, KEY0);
    send_pt(PT0);
    recv_ct(ct);
    n_vec++; if (last_ld_text !== PT0) begin n_err++; $display("FAIL single_core_text: got %h required %h", last_ld_text, PT0); end
    n_vec++; if (core_key_o !== KEY0) begin n_err++; $display("FAIL single_core_key: got %h required %h", core_key_o, KEY0); end
    n_vec++; if (ct !== CT0) begin n_err++; $display("FAIL single_ct: got %h required %h", ct, CT0); end
    n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL single_done_pulses: got %0d required 1", done_cnt - d0); end
    n_vec++; if (cnt_o !== 11'd1) begin n_err++; $display("FAIL single_cnt: got %0d required 1", cnt_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL single_busy_end: got %b required 0", busy_o); end
  endtask

  task automatic test_chaining();
    logic [127:0] pts [3];
    logic [127:0] chain, exp_text, exp_ct, ct;
    int l0 = ld_cnt;
    int d0 = done_cnt;
    pts[0] = 128'h3243f6a8885a308d313198a2e0370734;
    pts[1] = 128'hdeadbeef00112233cafebabe44556677;
    pts[2] = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    chain = KEY0;
    start_job(11'd3, KEY0, K1);
    for (int k = 0; k < 3; k++) begin
      send_pt(pts[k]);
      recv_ct(ct);
      exp_text = pts[k] ^ chain;
      exp_ct   = core_fn(exp_text, K1);
      n_vec++; if (last_ld_text !== exp_text) begin n_err++; $display("FAIL chain_text[%0d]: got %h required %h", k, last_ld_text, exp_text); end
      n_vec++; if (ct !== exp_ct) begin n_err++; $display("FAIL chain_ct[%0d]: got %h required %h", k, ct, exp_ct); end
      n_vec++; if (cnt_o !== CW'(k + 1)) begin n_err++; $display("FAIL chain_cnt[%0d]: got %0d required %0d", k, cnt_o, k + 1); end
      chain = exp_ct;
    end
    n_vec++; if (ld_cnt - l0 !== 3) begin n_err++; $display("FAIL chain_ld_pulses: got %0d required 3", ld_cnt - l0); end
    n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL chain_done_pulses: got %0d required 1", done_cnt - d0); end
  endtask

  task automatic test_backpressure();
    logic [127:0] p, snap;
    bit unstable = 1'b0;
    bit rdy_seen = 1'b0;
    int l0, d0;
    p = 128'h00000000111111112222222233333333;
    ct_ready_i = 1'b0;
    d0 = done_cnt;
    start_job(11'd1, IV1, K1);
    send_pt(p);
    wait_ct_valid();
    snap = ct_data_o;
    l0 = ld_cnt;
    for (int i = 0; i < 20; i++) begin
      if (ct_data_o !== snap || ct_valid_o !== 1'b1) unstable = 1'b1;
      if (pt_ready_o !== 1'b0) rdy_seen = 1'b1;
      @(negedge clk_i);
    end
    n_vec++; if (unstable) begin n_err++; $display("FAIL bp_ct_stable: ct_valid_o/ct_data_o changed while stalled, required stable"); end
    n_vec++; if (rdy_seen) begin n_err++; $display("FAIL bp_pt_ready: pt_ready_o was 1 while stalled, required 0"); end
    n_vec++; if (ld_cnt !== l0) begin n_err++; $display("FAIL bp_no_load: got %0d loads required 0", ld_cnt - l0); end
    n_vec++; if (snap !== core_fn(p ^ IV1, K1)) begin n_err++; $display("FAIL bp_ct: got %h required %h", snap, core_fn(p ^ IV1, K1)); end
    ct_ready_i = 1'b1;
    @(negedge clk_i);
    n_vec++; if (cnt_o !== 11'd1) begin n_err++; $display("FAIL bp_cnt: got %0d required 1", cnt_o); end
    n_vec++; if (ct_valid_o !== 1'b0) begin n_err++; $display("FAIL bp_valid_drop: got %b required 0", ct_valid_o); end
    n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL bp_done: got %0d required 1", done_cnt - d0); end
  endtask

  task automatic test_boundaries();
    logic [127:0] p0, p1, c0, c1, e0, e1;
    p0 = 128'h1111111122222222333333334444444f;
    p1 = 128'h99999999888888887777777766666666;
    @(negedge clk_i);
    start_i = 1'b1; len_i = 11'd0;
    @(negedge clk_i);
    start_i = 1'b0;
    n_vec++; if (done_o !== 1'b1) begin n_err++; $display("FAIL len0_done: got %b required 1", done_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL len0_busy: got %b required 0", busy_o); end
    @(negedge clk_i);
    n_vec++; if ({done_o, busy_o} !== 2'b00) begin n_err++; $display("FAIL len0_after: done/busy got %b required 00", {done_o, busy_o}); end
    start_job(11'd2, IV1, K1);
    send_pt(p0);
    @(negedge clk_i);
    start_i = 1'b1; len_i = 11'd5; iv_i = ~IV1; key_i = ~K1;
    @(negedge clk_i);
    start_i = 1'b0;
    recv_ct(c0);
    e0 = core_fn(p0 ^ IV1, K1);
    n_vec++; if (c0 !== e0) begin n_err++; $display("FAIL run_start_ct0: got %h required %h", c0, e0); end
    n_vec++; if (cnt_o !== 11'd1) begin n_err++; $display("FAIL run_start_cnt1: got %0d required 1", cnt_o); end
    send_pt(p1);
    recv_ct(c1);
    e1 = core_fn(p1 ^ e0, K1);
    n_vec++; if (last_ld_text !== (p1 ^ e0)) begin n_err++; $display("FAIL run_start_chain: got %h required %h", last_ld_text, p1 ^ e0); end
    n_vec++; if (c1 !== e1) begin n_err++; $display("FAIL run_start_ct1: got %h required %h", c1, e1); end
    n_vec++; if ({cnt_o, busy_o} !== {11'd2, 1'b0}) begin n_err++; $display("FAIL run_start_end: cnt=%0d busy=%b required cnt=2 busy=0", cnt_o, busy_o); end
  endtask

  task automatic test_clear_mid_job();
    logic [127:0] c;
    bit stray = 1'b0;
    start_job(11'd4, IV1, K1);
    send_pt(128'hab);
    recv_ct(c);
    send_pt(128'hcd);
    @(negedge clk_i);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    n_vec++;
    if ({busy_o, ct_valid_o, cnt_o} !== {2'b00, 11'd0}) begin
      n_err++; $display("FAIL clear_state: busy=%b ct_valid=%b cnt=%0d required 0 0 0", busy_o, ct_valid_o, cnt_o);
    end
    for (int i = 0; i < 15; i++) begin
      if (ct_valid_o || busy_o) stray = 1'b1;
      @(negedge clk_i);
    end
    n_vec++; if (stray) begin n_err++; $display("FAIL clear_late_done: late core done re-activated the sequencer, required ignored"); end
    n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL clear_err: got %b required 0", err_o); end
  endtask

  task automatic test_reset_mid_job();
    ct_ready_i = 1'b0;
    start_job(11'd1, IV1, K1);
    send_pt(128'h77);
    wait_ct_valid();
    rst_ni = 1'b0;
    #1;
    n_vec++;
    if ({pt_ready_o, core_ld_o, ct_valid_o, busy_o, done_o, err_o} !== 6'b0) begin
      n_err++; $display("FAIL rst_mid_flags: got %b required 000000", {pt_ready_o, core_ld_o, ct_valid_o, busy_o, done_o, err_o});
    end
    n_vec++;
    if ({cnt_o, ct_data_o, core_text_o, core_key_o} !== {11'd0, 384'h0}) begin
      n_err++; $display("FAIL rst_mid_data: cnt=%0d ct=%h required all zero", cnt_o, ct_data_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1; ct_ready_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_back_to_back();
    logic [127:0] c, e;
    start_job(11'd1, IV1, K1);
    send_pt(128'h1234);
    wait_ct_valid();
    n_vec++; if (done_o !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %b required 1", done_o); end
    start_i = 1'b1; len_i = 11'd1; iv_i = IV2; key_i = K1;
    @(negedge clk_i);
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL b2b_ignored: busy got %b required 0", busy_o); end
    @(negedge clk_i);
    start_i = 1'b0;
    n_vec++; if ({busy_o, pt_ready_o} !== 2'b11) begin n_err++; $display("FAIL b2b_accept: busy/pt_ready got %b required 11", {busy_o, pt_ready_o}); end
    send_pt(128'h5678);
    recv_ct(c);
    e = core_fn(128'h5678 ^ IV2, K1);
    n_vec++; if (c !== e) begin n_err++; $display("FAIL b2b_ct: got %h required %h", c, e); end
  endtask

`ifdef AES_CBC_SEQ_WATCHDOG_EN
  task automatic test_watchdog();
    int k = 0;
    int d0 = done_cnt;
    bit ctv = 1'b0;
    core_hang = 1'b1;
    start_job(11'd1, IV1, K1);
    send_pt(128'h99);
    while (busy_o && k < 200) begin
      @(negedge clk_i); k++;
      if (ct_valid_o) ctv = 1'b1;
    end
    n_vec++; if (k !== 65) begin n_err++; $display("FAIL wd_cycles: left RUN after %0d cycles required 65", k); end
    n_vec++; if ({err_o, busy_o} !== 2'b10) begin n_err++; $display("FAIL wd_err: err/busy got %b required 10", {err_o, busy_o}); end
    n_vec++; if (done_cnt !== d0 || ctv) begin n_err++; $display("FAIL wd_quiet: done pulses %0d ct_valid seen %b required 0 0", done_cnt - d0, ctv); end
    core_hang = 1'b0;
    start_job(11'd1, IV1, K1);
    n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL wd_clear_on_start: got %b required 0", err_o); end
    send_pt(128'h1);
    wait_ct_valid();
    @(negedge clk_i);
  endtask
`else
  task automatic test_watchdog();
    n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL no_wd_err: got %b required 0", err_o); end
  endtask
`endif

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; len_i = 11'd0;
    iv_i = 128'h0; key_i = 128'h0; pt_valid_i = 1'b0; pt_data_i = 128'h0;
    ct_ready_i = 1'b1;
    test_reset();
    test_single_block();
    test_chaining();
    test_backpressure();
    test_boundaries();
    test_clear_mid_job();
    test_reset_mid_job();
    test_back_to_back();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/aes_cbc_sequencer.md
Name: aes_cbc_sequencer

Overview:
Controller that sequences one iterative AES-128 cipher core (ld/done interface) through a CBC encryption job of `len_i` 128-bit blocks.
- Takes plaintext blocks and produces ciphertext blocks on valid/ready streams.
- XORs each plaintext block with the chaining value (IV, then the previous ciphertext).
- Issues one load pulse per block and counts completed blocks.
- Sits between the streamer-side block stackers/unstackers and the cipher core, replacing ad-hoc start/busy logic inside the engine.

Parameters:
- CNT_LEN, 1024, maximum blocks per job; counters are $clog2(CNT_LEN)+1 bits wide.
- TIMEOUT, 64, maximum RUN-state cycles before watchdog error (only used with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous soft clear.
- start_i  in  1  job start pulse.
- len_i  in  $clog2(CNT_LEN)+1  number of blocks in the job.
- iv_i  in  128  CBC initialisation vector.
- key_i  in  128  cipher key.
- pt_valid_i  in  1  plaintext valid.
- pt_ready_o  out  1  plaintext ready.
- pt_data_i  in  128  plaintext block.
- core_ld_o  out  1  core load pulse.
- core_key_o  out  128  key to core.
- core_text_o  out  128  chained text to core.
- core_done_i  in  1  core done pulse.
- core_text_i  in  128  core ciphertext.
- ct_valid_o  out  1  ciphertext valid.
- ct_ready_i  in  1  ciphertext ready.
- ct_data_o  out  128  ciphertext block.
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle pulse at job end.
- cnt_o  out  $clog2(CNT_LEN)+1  blocks delivered in the current job.
- err_o  out  1  sticky watchdog error.

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, and the chain, key and text registers are 0.
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- clear_i has highest priority. It forces IDLE and zeroes cnt_o, err_o, ct_valid_o and core_ld_o. Chain and key registers are untouched.
- IDLE (busy_o=0):
  - start_i with len_i!=0: latch chain<=iv_i, key<=key_i, cnt<=0; next state WAIT_IN.
  - start_i with len_i==0: done_o pulses on the next cycle and the FSM stays in IDLE.
  - start_i outside IDLE is ignored.
- WAIT_IN: pt_ready_o=1, decoded from state only and never dependent on pt_valid_i. On pt_valid_i&pt_ready_o: text<=pt_data_i^chain; next state LOAD.
- LOAD: core_ld_o=1 for exactly one cycle, with core_key_o/core_text_o stable from this cycle until done; next state RUN.
- RUN:
  - Wait for core_done_i. On done: ct<=core_text_i, chain<=core_text_i; next state OUT.
  - core_done_i in any other state is ignored.
- OUT:
  - ct_valid_o=1 (registered) with ct_data_o stable until ct_valid_o&ct_ready_i.
  - On that handshake: cnt<=cnt+1. If cnt+1==len_i, go to IDLE with a done_o pulse in the same transition cycle; otherwise go to WAIT_IN.
  - ct_valid_o never drops without a handshake.
- busy_o=1 in every state except IDLE. cnt_o is the registered count of delivered blocks.
- Latency:
  - Pt handshake at cycle t gives core_ld_o at t+1.
  - Core done at cycle d gives ct_valid_o at d+1.
  - Minimum per block: 3 + core latency cycles, with zero backpressure.
- len_i is sampled only at start; it is held in an internal register, and changes mid-job have no effect.
- Back-to-back jobs: start_i in the done_o cycle is ignored, because the FSM is still leaving OUT. A new start is accepted from the following cycle.
- Reset mid-job: immediate return to the reset values; no partial ciphertext is emitted.

Optional Feature:
Macro AES_CBC_SEQ_WATCHDOG_EN.
- With the macro:
  - A counter runs in RUN, cleared on entry.
  - If it reaches TIMEOUT without core_done_i, err_o sets (sticky) and the FSM returns to IDLE with no done_o and no ct_valid_o.
  - err_o clears on clear_i or on an accepted start_i.
- Without the macro: err_o is tied 0, RUN waits indefinitely, and TIMEOUT is unused.

Test Plan:
- Single block, ECB-equivalent:
  - Stimulus: key=000102030405060708090a0b0c0d0e0f, iv=0, pt=00112233445566778899aabbccddeeff, len=1, core model with 10-cycle latency.
  - Expected: core_text_o=pt, ct=69c4e0d86a7b0430d8cdb78070b4c55a, done_o one pulse, cnt_o=1.
- Chaining:
  - Stimulus: len=3, iv=000102...0f, random pt.
  - Expected: core_text_o for block k equals pt[k]^ct[k-1] (pt[0]^iv for k=0); exactly 3 core_ld_o pulses; cnt_o steps 1,2,3.
- Backpressure:
  - Stimulus: ct_ready_i=0 for 20 cycles after ct_valid_o.
  - Expected: ct_data_o stable, pt_ready_o=0, no core_ld_o; a single block is delivered when ready rises.
- Boundaries:
  - Stimulus: start with len=0; then start_i pulsed during RUN.
  - Expected: done_o one cycle after the len=0 start with busy_o never 1; the start during RUN has no effect on cnt/chain.
- Clear and reset mid-job:
  - Stimulus: clear_i in RUN of block 2/4; separately, assert rst_ni low in OUT.
  - Expected: IDLE next cycle, cnt_o=0, ct_valid_o=0, a late core_done_i is ignored; reset values are seen immediately on reset.
- Watchdog (macro on):
  - Stimulus: TIMEOUT=64, core never asserts done.
  - Expected: err_o=1 after 64 RUN cycles, busy_o=0, no done_o; err_o clears on the next start.
